chunked_adder_sequencer: RTL and testbench
==========================================

// Module: chunked_adder_sequencer
// PURPOSE
//   Multi-cycle wide adder. One CHUNK_W-bit ripple_carry_adder is reused over NUM_CHUNKS cycles.
//   The carry is held in a register between chunks.
//   Sits between an operand producer and a result consumer, with valid/ready on both sides.
//   Trades latency for area in the approximate-arithmetic adder family.
// PARAMETERS
//   CHUNK_W    12  width of the shared adder slice
//   NUM_CHUNKS 4   chunks per operand; TOT_W = CHUNK_W*NUM_CHUNKS (48 by default)
// PORTS
//   clk_i           in   1        single clock, rising edge
//   rst_i           in   1        reset, synchronous, active-high
//   start_valid_i   in   1        operands valid
//   start_ready_o   out  1        block can accept operands (1 only in IDLE)
//   add1_i          in   TOT_W    operand A
//   add2_i          in   TOT_W    operand B
//   carry_i         in   1        carry-in
//   result_o        out  TOT_W+1  {carry_out, sum}
//   result_valid_o  out  1        result_o holds a completed sum
//   result_ready_i  in   1        consumer takes the result
//   busy_o          out  1        1 in RUN or DONE
// BEHAVIOUR
//   Reset: state=IDLE, result_o=0, result_valid_o=0, busy_o=0, chunk index=0, carry reg=0.
//     start_ready_o=1 on the first cycle after reset.
//   FSM IDLE -> RUN: on start_valid_i & start_ready_o, latch add1_i/add2_i/carry_i. Index k=0.
//   RUN: each cycle, slice k = {add1[k], add2[k], carry_reg} goes through the adder.
//     Write sum bits [k*CHUNK_W +: CHUNK_W] of the result register.
//     carry_reg <= carry out; k <= k+1.
//   RUN -> DONE: on the edge that processes k=NUM_CHUNKS-1; result_o[TOT_W] <= final carry.
//   Latency: handshake at edge 0, result_valid_o=1 after edge NUM_CHUNKS (4 cycles by default).
//   DONE: result_valid_o=1; result_o stable until it is consumed.
//     On result_ready_i -> IDLE, result_valid_o=0. result_o keeps its last value.
//   No overlap: operands are not accepted in RUN/DONE.
//     start_valid_i is ignored there, and input operand changes are ignored after the latch.
//   Index wraps to 0 on entry to IDLE, never past NUM_CHUNKS-1.
//   rst_i mid-RUN/DONE: operation aborted, reset values next cycle, no partial result exposed.
//   Carry chain is exact across chunk boundaries: the full-width result equals add1+add2+carry_i.
// CONFIGURATION
//   Macro LOWER_OR_EN.
//   Defined: chunk 0 is computed as bitwise add1[0]|add2[0] (lower-part-OR approximation).
//     Carry into chunk 1 is forced to 0 and carry_i is ignored; chunks 1..N-1 stay exact.
//     Latency is unchanged.
//   Undefined: all chunks exact, carry_i used.
// STRUCTURE
//   Package adder_ctrl_pkg: state typedef {IDLE, RUN, DONE}; CHUNK_IDX_W = $clog2(NUM_CHUNKS).
//   Sub-module: one ripple_carry_adder instance (width=CHUNK_W).
//     Slice muxing, carry register, FSM and result register live in this module.
// TESTING (CHUNK_W=12, NUM_CHUNKS=4)
//   1. Full carry ripple: A=0xFFFFFFFFFFFF, B=0x000000000001, cin=0, result_ready_i=1.
//      -> result_o=0x1_000000000000; valid 4 cycles after handshake.
//   2. Carry-in: A=0x123456789ABC, B=0x111111111111, cin=1.
//      -> result_o=0x0_23456789ABCE.
//   3. Backpressure: result_ready_i=0 for 10 cycles after done, start_valid_i=1 throughout.
//      -> valid held, result_o stable, start_ready_o=0, no new accept.
//   4. Reset mid-op: rst_i at second RUN cycle.
//      -> next cycle result_valid_o=0, busy_o=0, result_o=0, start_ready_o=1.
//   5. LOWER_OR_EN: A=0x000000000FFF, B=0x000000000001, cin=1.
//      -> result_o=0x0_000000000FFF (exact build gives 0x0_000000001001).
//   6. 1000 random operand pairs with random ready stalls.
//      -> every result matches A+B+cin (exact build); one result per handshake.

Source files
------------

// File: rtl/adder_ctrl_pkg.sv
// Shared types and default sizing for the chunked adder sequencer.
package adder_ctrl_pkg;

    localparam int CHUNK_W_DEF    = 12;
    localparam int NUM_CHUNKS_DEF = 4;
    localparam int CHUNK_IDX_W    = $clog2(NUM_CHUNKS_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// Combinational W-bit ripple-carry adder slice reused by the chunk sequencer.
module ripple_carry_adder #(
    parameter int W = 12
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_i,
    output logic [W-1:0] sum_o,
    output logic         c_o
);

    logic carry;

    always_comb begin
        sum_o = '0;
        carry = c_i;
        for (int i = 0; i < W; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
            carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
        end
        c_o = carry;
    end

endmodule

// File: rtl/chunked_adder_sequencer.sv
// Wide adder computed one CHUNK_W slice per cycle; LOWER_OR_EN selects the lower-part-OR approximation.
// state | meaning
// IDLE  | ready for operands, result_o holds the last sum
// RUN   | one slice per cycle, idx_q selects the slice, carry_q links slices
// DONE  | result_valid_o high until result_ready_i
module chunked_adder_sequencer
    import adder_ctrl_pkg::*;
#(
    parameter int CHUNK_W    = CHUNK_W_DEF,
    parameter int NUM_CHUNKS = NUM_CHUNKS_DEF,
    localparam int TOT_W     = CHUNK_W * NUM_CHUNKS
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_valid_i,
    output logic             start_ready_o,
    input  logic [TOT_W-1:0] add1_i,
    input  logic [TOT_W-1:0] add2_i,
    input  logic             carry_i,
    output logic [TOT_W:0]   result_o,
    output logic             result_valid_o,
    input  logic             result_ready_i,
    output logic             busy_o
);

    localparam int            IW   = idx_w(NUM_CHUNKS);
    localparam logic [IW-1:0] LAST = IW'(NUM_CHUNKS - 1);

    state_e             state_q;
    logic [IW-1:0]      idx_q;
    logic               carry_q;
    logic [TOT_W-1:0]   a_q, b_q;
    logic [TOT_W:0]     result_q;
    logic               valid_q, busy_q, ready_q;

    logic [CHUNK_W-1:0] a_sl, b_sl, sum_rca, sum_sl;
    logic               cout_rca, cout_sl;

    assign a_sl = a_q[int'(idx_q)*CHUNK_W +: CHUNK_W];
    assign b_sl = b_q[int'(idx_q)*CHUNK_W +: CHUNK_W];

    ripple_carry_adder #(.W(CHUNK_W)) u_rca (
        .a_i   (a_sl),
        .b_i   (b_sl),
        .c_i   (carry_q),
        .sum_o (sum_rca),
        .c_o   (cout_rca)
    );

`ifdef LOWER_OR_EN
    // Lowest slice is OR-approximated and never carries into slice 1.
    always_comb begin
        sum_sl  = sum_rca;
        cout_sl = cout_rca;
        if (idx_q == '0) begin
            sum_sl  = a_sl | b_sl;
            cout_sl = 1'b0;
        end
    end
`else
    assign sum_sl  = sum_rca;
    assign cout_sl = cout_rca;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_valid_i && ready_q) begin
                        a_q     <= add1_i;
                        b_q     <= add2_i;
`ifdef LOWER_OR_EN
                        carry_q <= 1'b0;
`else
                        carry_q <= carry_i;
`endif
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    result_q[int'(idx_q)*CHUNK_W +: CHUNK_W] <= sum_sl;
                    carry_q <= cout_sl;
                    if (idx_q == LAST) begin
                        result_q[TOT_W] <= cout_sl;
                        valid_q         <= 1'b1;
                        state_q         <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (result_ready_i) begin
                        idx_q   <= '0;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    idx_q   <= '0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign start_ready_o  = ready_q;
    assign result_o       = result_q;
    assign result_valid_o = valid_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_chunked_adder_sequencer.sv
// Directed vector table plus handwritten corner sequences and a random sweep for chunked_adder_sequencer.
module tb_chunked_adder_sequencer;

    localparam int TOT_W = 48;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_valid;
    logic             start_ready;
    logic [TOT_W-1:0] add1, add2;
    logic             cin;
    logic [TOT_W:0]   result;
    logic             result_valid;
    logic             result_ready;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    chunked_adder_sequencer dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_valid_i  (start_valid),
        .start_ready_o  (start_ready),
        .add1_i         (add1),
        .add2_i         (add2),
        .carry_i        (cin),
        .result_o       (result),
        .result_valid_o (result_valid),
        .result_ready_i (result_ready),
        .busy_o         (busy)
    );

    typedef struct {
        logic [TOT_W-1:0] a;
        logic [TOT_W-1:0] b;
        logic             c;
        logic [TOT_W:0]   exp_exact;
        logic [TOT_W:0]   exp_or;
        int               stall;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [TOT_W:0] act, input logic [TOT_W:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [TOT_W:0] model(input logic [TOT_W-1:0] a, input logic [TOT_W-1:0] b,
                                             input logic c);
`ifdef LOWER_OR_EN
        logic [36:0] up;
        up = {1'b0, a[47:12]} + {1'b0, b[47:12]};
        return {up, a[11:0] | b[11:0]};
`else
        return {1'b0, a} + {1'b0, b} + {{TOT_W{1'b0}}, c};
`endif
    endfunction

    task automatic wait_start_ready(input string name);
        int n = 0;
        while (!start_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, " start_ready"}, {48'd0, start_ready}, 49'd1);
    endtask

    // Enters after an edge; leaves one cycle after the result was consumed.
    task automatic do_op(input string name, input logic [TOT_W-1:0] a, input logic [TOT_W-1:0] b,
                         input logic c, input logic [TOT_W:0] exp, input int stall,
                         input bit hold_start, input bit full_chk);
        int lat;
        add1 = a; add2 = b; cin = c;
        start_valid  = 1'b1;
        result_ready = 1'b0;
        wait_start_ready(name);
        @(posedge clk); #1;
        start_valid = 1'b0;
        add1 = ~a; add2 = ~b; cin = ~c;
        if (full_chk) begin
            check({name, " busy_run"}, {48'd0, busy}, 49'd1);
            check({name, " ready_run"}, {48'd0, start_ready}, 49'd0);
        end
        lat = 0;
        while (!result_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, " latency"}, 49'(lat), 49'd4);
        check({name, " result"}, result, exp);
        start_valid = hold_start;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            if (hold_start) begin
                check({name, " stall_valid"}, {48'd0, result_valid}, 49'd1);
                check({name, " stall_result"}, result, exp);
                check({name, " stall_ready"}, {48'd0, start_ready}, 49'd0);
            end
        end
        start_valid  = 1'b0;
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        if (full_chk) begin
            check({name, " valid_clr"}, {48'd0, result_valid}, 49'd0);
            check({name, " busy_clr"}, {48'd0, busy}, 49'd0);
            check({name, " ready_back"}, {48'd0, start_ready}, 49'd1);
            check({name, " result_kept"}, result, exp);
        end
    endtask

    initial begin
        logic [63:0] ra, rb;
        logic        rc;
        int          lat;

        vecs[0] = '{48'hFFFFFFFFFFFF, 48'h000000000001, 1'b0, 49'h1_000000000000, 49'h0_FFFFFFFFFFFF, 0};
        vecs[1] = '{48'h123456789ABC, 48'h111111111111, 1'b1, 49'h0_23456789ABCE, 49'h0_23456789ABBD, 1};
        vecs[2] = '{48'h000000000000, 48'h000000000000, 1'b0, 49'h0_000000000000, 49'h0_000000000000, 0};
        vecs[3] = '{48'h000000000000, 48'h000000000000, 1'b1, 49'h0_000000000001, 49'h0_000000000000, 2};
        vecs[4] = '{48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 1'b1, 49'h1_FFFFFFFFFFFF, 49'h1_FFFFFFFFEFFF, 0};
        vecs[5] = '{48'h000000000FFF, 48'h000000000001, 1'b1, 49'h0_000000001001, 49'h0_000000000FFF, 0};
        vecs[6] = '{48'h000FFF000FFF, 48'h000001000001, 1'b0, 49'h0_001000001000, 49'h0_001000000FFF, 3};

        rst = 1'b1; start_valid = 1'b0; add1 = '0; add2 = '0; cin = 1'b0; result_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset result", result, 49'd0);
        check("reset valid", {48'd0, result_valid}, 49'd0);
        check("reset busy", {48'd0, busy}, 49'd0);
        check("reset ready", {48'd0, start_ready}, 49'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
`ifdef LOWER_OR_EN
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].exp_or, vecs[i].stall, 1'b0, 1'b1);
`else
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].exp_exact, vecs[i].stall, 1'b0, 1'b1);
`endif
        end

        // Backpressure: consumer stalls 10 cycles with start_valid held high.
        do_op("backpressure", 48'hABCDEF012345, 48'h0F0F0F0F0F0F, 1'b1,
              model(48'hABCDEF012345, 48'h0F0F0F0F0F0F, 1'b1), 10, 1'b1, 1'b1);

        // Reset during the second RUN cycle.
        add1 = 48'h555555555555; add2 = 48'hAAAAAAAAAAAA; cin = 1'b1; start_valid = 1'b1;
        wait_start_ready("rst_run");
        @(posedge clk); #1;
        start_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_run valid", {48'd0, result_valid}, 49'd0);
        check("rst_run busy", {48'd0, busy}, 49'd0);
        check("rst_run result", result, 49'd0);
        check("rst_run ready", {48'd0, start_ready}, 49'd1);

        // Reset while a finished result waits in DONE.
        add1 = 48'h000000000FFF; add2 = 48'h000000000FFF; cin = 1'b0; start_valid = 1'b1;
        wait_start_ready("rst_done");
        @(posedge clk); #1;
        start_valid = 1'b0;
        lat = 0;
        while (!result_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("rst_done valid_pre", {48'd0, result_valid}, 49'd1);
        check("rst_done result_pre", result, model(48'h000000000FFF, 48'h000000000FFF, 1'b0));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_done valid", {48'd0, result_valid}, 49'd0);
        check("rst_done result", result, 49'd0);
        check("rst_done ready", {48'd0, start_ready}, 49'd1);

        for (int n = 0; n < 1000; n++) begin
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            rc = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            do_op($sformatf("rand%0d", n), ra[47:0], rb[47:0], rc, model(ra[47:0], rb[47:0], rc),
                  int'($urandom_range(0, 3)), 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
